// File: rtl/d05200_owl_pkg.sv
// d05200_owl_pkg: definitions shared by both ends of the D05200 one-wire link
// (this host and the responder inside d05200_dc_top).
//   state_e   : host FSM states
//   drive_e   : what the host does with the pad during the current cell
//   frame constants and drive-width helper (width in clocks for a cell size)
package d05200_owl_pkg;

  localparam int HDR_BITS    = 8;
  localparam int DATA_BITS   = 8;
  localparam int FRAME_CELLS = 28;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BREAK,
    S_GAP,
    S_HDR,
    S_WDAT,
    S_PAR,
    S_TURN,
    S_RSLOT,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    DRV_NONE,  // released for the whole cell
    DRV_FULL,  // low for the whole cell (break)
    DRV_ONE,   // data 1: low for a quarter cell
    DRV_ZERO,  // data 0: low for three quarters of a cell
    DRV_SLOT   // read/ack slot opener: low for an eighth of a cell
  } drive_e;

  // Low-drive length in clocks of one cell of cell_cyc clocks.
  function automatic int drive_len(input drive_e d, input int cell_cyc);
    case (d)
      DRV_FULL: return cell_cyc;
      DRV_ONE:  return cell_cyc / 4;
      DRV_ZERO: return (3 * cell_cyc) / 4;
      DRV_SLOT: return cell_cyc / 8;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/d05200_owl_cell_timer.sv
// d05200_owl_cell_timer: clock counter inside one OWL bit cell.
//   clk, rst   : clock, asynchronous active-high reset
//   run        : count while high; held at 0 otherwise
//   drive      : drive kind of the current cell
//   cell_end   : strobe on the last clock of the cell
//   drive_end  : strobe on the last clock of the low-drive window
//   sample     : strobe at cell offset CELL_CYC/2
module d05200_owl_cell_timer
  import d05200_owl_pkg::*;
#(
  parameter int CELL_CYC = 64
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   run,
  input  drive_e drive,
  output logic   cell_end,
  output logic   drive_end,
  output logic   sample
);

  localparam int CW = $clog2(CELL_CYC);
  localparam logic [CW-1:0] CELL_LAST = CW'(CELL_CYC - 1);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(CELL_CYC / 2);
  localparam logic [CW-1:0] ONE_LAST  = CW'(drive_len(DRV_ONE, CELL_CYC) - 1);
  localparam logic [CW-1:0] ZERO_LAST = CW'(drive_len(DRV_ZERO, CELL_CYC) - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(drive_len(DRV_SLOT, CELL_CYC) - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] drive_last;
  logic          has_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || cell_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    drive_last = '0;
    has_end    = 1'b0;
    case (drive)
      DRV_ONE:  begin has_end = 1'b1; drive_last = ONE_LAST;  end
      DRV_ZERO: begin has_end = 1'b1; drive_last = ZERO_LAST; end
      DRV_SLOT: begin has_end = 1'b1; drive_last = SLOT_LAST; end
      default:  begin has_end = 1'b0; drive_last = '0;        end
    endcase
  end

  assign cell_end  = run && (cnt == CELL_LAST);
  assign drive_end = run && has_end && (cnt == drive_last);
  assign sample    = run && (cnt == SAMPLE_AT);

endmodule

// File: rtl/d05200_owl_host.sv
// d05200_owl_host: initiator end of the D05200 one-wire link.
//   CLK, RST              : clock, asynchronous active-high reset
//   CMD_VLD/CMD_RDY       : command handshake (accepted on VLD & RDY)
//   CMD_WR, CMD_ADDR, CMD_WDAT : 1=write/0=read, 7-bit address, write data
//   RSP_VLD               : one-cycle response pulse
//   RSP_RDAT, RSP_ERR     : read data (0x00 after writes), parity error / NACK
//   OWL_DI                : asynchronous pad input
//   OWL_DO, OWL_OE        : pad output (always 0), 1 = pull line low
module d05200_owl_host
  import d05200_owl_pkg::*;
#(
  parameter int CELL_CYC    = 64,
  parameter int BREAK_CELLS = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VLD,
  output logic       CMD_RDY,
  input  logic       CMD_WR,
  input  logic [6:0] CMD_ADDR,
  input  logic [7:0] CMD_WDAT,
  output logic       RSP_VLD,
  output logic [7:0] RSP_RDAT,
  output logic       RSP_ERR,
  input  logic       OWL_DI,
  output logic       OWL_DO,
  output logic       OWL_OE
);

  // Cell index of the last cell of each phase within the frame.
  localparam logic [4:0] BRK_LAST   = 5'(BREAK_CELLS - 1);
  localparam logic [4:0] HDR_LAST   = 5'(BREAK_CELLS + HDR_BITS);
  localparam logic [4:0] WDAT_LAST  = 5'(BREAK_CELLS + HDR_BITS + DATA_BITS);
  localparam logic [4:0] FRAME_LAST = 5'(BREAK_CELLS + HDR_BITS + DATA_BITS + 3);

  state_e      state;
  logic [4:0]  idx;
  logic [15:0] tx_sh;
  logic        par_bit;
  logic        wr_q;
  logic [8:0]  rx_sh;
  logic        di_s1, di_s2;
  drive_e      drive;
  logic        run, cell_end, drive_end, sample;

  assign OWL_DO = 1'b0;
  assign run    = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    drive = DRV_NONE;
    case (state)
      S_BREAK:      drive = DRV_FULL;
      S_HDR,
      S_WDAT:       drive = tx_sh[15] ? DRV_ONE : DRV_ZERO;
      S_PAR:        drive = par_bit ? DRV_ONE : DRV_ZERO;
      S_RSLOT:      drive = DRV_SLOT;
      default:      drive = DRV_NONE;
    endcase
  end

  d05200_owl_cell_timer #(
    .CELL_CYC (CELL_CYC)
  ) u_timer (
    .clk       (CLK),
    .rst       (RST),
    .run       (run),
    .drive     (drive),
    .cell_end  (cell_end),
    .drive_end (drive_end),
    .sample    (sample)
  );

  // Idle line is high, so the synchroniser resets to 1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      di_s1 <= 1'b1;
      di_s2 <= 1'b1;
    end else begin
      di_s1 <= OWL_DI;
      di_s2 <= di_s1;
    end
  end

  // OWL_OE is registered: it is raised on the edge that starts a driven cell
  // and dropped on the edge that ends the drive window, so it is high for
  // cell offsets 0 .. width-1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      idx      <= '0;
      tx_sh    <= '0;
      par_bit  <= 1'b0;
      wr_q     <= 1'b0;
      rx_sh    <= '0;
      CMD_RDY  <= 1'b1;
      RSP_VLD  <= 1'b0;
      RSP_RDAT <= '0;
      RSP_ERR  <= 1'b0;
      OWL_OE   <= 1'b0;
    end else begin
      RSP_VLD <= 1'b0;
      if (sample && (state == S_RSLOT)) begin
        rx_sh <= {rx_sh[7:0], di_s2};
      end
      case (state)
        S_IDLE: begin
          if (CMD_VLD) begin
            state   <= S_BREAK;
            CMD_RDY <= 1'b0;
            OWL_OE  <= 1'b1;
            idx     <= '0;
            tx_sh   <= {CMD_WR, CMD_ADDR, CMD_WDAT};
            wr_q    <= CMD_WR;
            par_bit <= CMD_WR ? ^{CMD_WR, CMD_ADDR, CMD_WDAT} : ^{CMD_WR, CMD_ADDR};
            rx_sh   <= '0;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          CMD_RDY <= 1'b1;
        end
        default: begin
          if (cell_end) begin
            idx    <= (idx == FRAME_LAST) ? 5'd0 : idx + 5'd1;
            OWL_OE <= 1'b1;
            case (state)
              S_BREAK: begin
                if (idx == BRK_LAST) begin
                  state  <= S_GAP;
                  OWL_OE <= 1'b0;
                end
              end
              S_GAP: state <= S_HDR;
              S_HDR: begin
                tx_sh <= tx_sh << 1;
                if (idx == HDR_LAST) state <= wr_q ? S_WDAT : S_PAR;
              end
              S_WDAT: begin
                tx_sh <= tx_sh << 1;
                if (idx == WDAT_LAST) state <= S_PAR;
              end
              S_PAR: begin
                state  <= S_TURN;
                OWL_OE <= 1'b0;
              end
              S_TURN: state <= S_RSLOT;
              S_RSLOT: begin
                if (idx == FRAME_LAST) begin
                  state    <= S_DONE;
                  OWL_OE   <= 1'b0;
                  RSP_VLD  <= 1'b1;
                  // Writes sample only the ACK slot, which lands in rx_sh[0].
                  RSP_RDAT <= wr_q ? 8'h00 : rx_sh[8:1];
                  RSP_ERR  <= wr_q ? rx_sh[0] : ^rx_sh;
                end
              end
              default: begin
                state  <= S_IDLE;
                OWL_OE <= 1'b0;
              end
            endcase
          end else if (drive_end) begin
            OWL_OE <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d05200_owl_host.sv
// tb_d05200_owl_host: directed bench for d05200_owl_host with CELL_CYC=16,
// BREAK_CELLS=8. A small responder pulls the line low during slot cells for
// 0 bits; the host's OWL_OE is recorded per cycle and decoded into per-cell
// low widths (16 break, 4 one, 12 zero, 2 slot, 0 released).
module tb_d05200_owl_host;

  localparam int CC  = 16;
  localparam int BC  = 8;
  localparam int NTR = 452;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_vld = 1'b0;
  logic       cmd_rdy;
  logic       cmd_wr = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdat = '0;
  logic       rsp_vld;
  logic [7:0] rsp_rdat;
  logic       rsp_err;
  logic       owl_di;
  logic       owl_do;
  logic       owl_oe;

  logic       resp_active = 1'b0;
  logic [8:0] resp_bits = '0;
  int         fcyc = 0;
  logic       fwr = 1'b0;
  logic       resp_low;
  int         r_cell, r_off;

  int checks = 0;
  int errors = 0;

  logic       oe_tr  [1:NTR];
  logic       vld_tr [1:NTR];
  logic       rdy_tr [1:NTR];
  logic [7:0] cap_rdat;
  logic       cap_err;

  always #5 clk = ~clk;

  d05200_owl_host #(
    .CELL_CYC    (CC),
    .BREAK_CELLS (BC)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .CMD_VLD  (cmd_vld),
    .CMD_RDY  (cmd_rdy),
    .CMD_WR   (cmd_wr),
    .CMD_ADDR (cmd_addr),
    .CMD_WDAT (cmd_wdat),
    .RSP_VLD  (rsp_vld),
    .RSP_RDAT (rsp_rdat),
    .RSP_ERR  (rsp_err),
    .OWL_DI   (owl_di),
    .OWL_DO   (owl_do),
    .OWL_OE   (owl_oe)
  );

  // Wired-AND line with pull-up.
  assign owl_di = ~(owl_oe | resp_low);

  // Responder frame clock: fcyc = k during cycle k after the accepting edge.
  always @(posedge clk) begin
    if (cmd_vld && cmd_rdy) begin
      fcyc <= 1;
      fwr  <= cmd_wr;
    end else if (fcyc != 0 && fcyc < 100000) begin
      fcyc <= fcyc + 1;
    end
  end

  // Slots: read cells 19..27 (data MSB first, then parity), write cell 27.
  always_comb begin
    resp_low = 1'b0;
    r_cell   = 0;
    r_off    = 0;
    if (resp_active && fcyc > 0) begin
      r_cell = (fcyc - 1) / CC;
      r_off  = (fcyc - 1) % CC;
      if (r_cell >= (fwr ? 27 : 19) && r_cell <= 27 && r_off < 12 && !resp_bits[27 - r_cell])
        resp_low = 1'b1;
    end
  end

  function automatic int exp_width(input logic wr, input logic [7:0] hdr,
                                   input logic [7:0] wdat, input logic par, input int c);
    if (c < BC) return CC;
    if (c == BC) return 0;
    if (c <= BC + 8) return hdr[BC + 8 - c] ? CC / 4 : 3 * CC / 4;
    if (wr) begin
      if (c <= BC + 16) return wdat[BC + 16 - c] ? CC / 4 : 3 * CC / 4;
      if (c == BC + 17) return par ? CC / 4 : 3 * CC / 4;
      if (c == BC + 18) return 0;
      return CC / 8;
    end
    if (c == BC + 9) return par ? CC / 4 : 3 * CC / 4;
    if (c == BC + 10) return 0;
    return CC / 8;
  endfunction

  function automatic int meas_width(input int c);
    int n = 0;
    for (int k = c * CC + 1; k <= c * CC + CC; k++) if (oe_tr[k] === 1'b1) n++;
    return n;
  endfunction

  function automatic int vld_first();
    for (int k = 1; k <= NTR; k++) if (vld_tr[k] === 1'b1) return k;
    return 0;
  endfunction

  function automatic int vld_count();
    int n = 0;
    for (int k = 1; k <= NTR; k++) if (vld_tr[k] === 1'b1) n++;
    return n;
  endfunction

  // Present a command and return on the accepting edge (bounded wait).
  task automatic issue(input logic wr, input logic [6:0] addr, input logic [7:0] wdat);
    bit ok = 0;
    @(negedge clk);
    cmd_wr = wr; cmd_addr = addr; cmd_wdat = wdat; cmd_vld = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (cmd_rdy === 1'b1) ok = 1;
      else @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept: cmd_rdy never high within 2000 cycles");
    end else begin
      @(posedge clk);
    end
  endtask

  // Record cycles 1..NTR after the accepting edge.
  task automatic trace(input bit drop, input bit swap);
    cap_rdat = 'x;
    cap_err  = 1'bx;
    for (int k = 1; k <= NTR; k++) begin
      #1;
      oe_tr[k]  = owl_oe;
      vld_tr[k] = rsp_vld;
      rdy_tr[k] = cmd_rdy;
      if (rsp_vld === 1'b1) begin
        cap_rdat = rsp_rdat;
        cap_err  = rsp_err;
      end
      if (k == 1) begin
        if (drop) cmd_vld = 1'b0;
        if (swap) begin cmd_wr = 1'b0; cmd_addr = 7'h7F; cmd_wdat = 8'h00; end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", cmd_rdy); end
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", rsp_vld); end
    checks++; if (rsp_rdat !== 8'h00) begin errors++; $display("FAIL reset_rdat: got %h want 00", rsp_rdat); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", rsp_err); end
    checks++; if (owl_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", owl_oe); end
    checks++; if (owl_do !== 1'b0) begin errors++; $display("FAIL reset_do: got %b want 0", owl_do); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (cmd_rdy !== 1'b1 || owl_oe !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: rdy %b oe %b want 1 0", cmd_rdy, owl_oe);
    end
  endtask

  // HDR {1,0x15} = 0x95, WDAT 0xA5; even parity over both is 0.
  task automatic test_write_ack();
    resp_active = 1'b1; resp_bits = {8'h3C, 1'b0};
    issue(1'b1, 7'h15, 8'hA5);
    trace(1'b1, 1'b0);
    for (int c = 0; c < 28; c++) begin
      checks++;
      if (meas_width(c) !== exp_width(1'b1, 8'h95, 8'hA5, 1'b0, c)) begin
        errors++; $display("FAIL write_ack cell %0d: width %0d want %0d", c, meas_width(c), exp_width(1'b1, 8'h95, 8'hA5, 1'b0, c));
      end
    end
    checks++; if (vld_first() !== 449) begin errors++; $display("FAIL write_ack vld_cycle: got %0d want 449", vld_first()); end
    checks++; if (vld_count() !== 1) begin errors++; $display("FAIL write_ack vld_count: got %0d want 1", vld_count()); end
    checks++; if (rdy_tr[449] !== 1'b0 || rdy_tr[450] !== 1'b1) begin
      errors++; $display("FAIL write_ack rdy: cyc449 %b cyc450 %b want 0 1", rdy_tr[449], rdy_tr[450]);
    end
    checks++; if (cap_err !== 1'b0 || cap_rdat !== 8'h00) begin
      errors++; $display("FAIL write_ack rsp: err %b rdat %h want 0 00", cap_err, cap_rdat);
    end
  endtask

  // HDR {0,0x7F} = 0x7F, parity 1; responder returns 0x3C, parity 0.
  task automatic test_read();
    resp_active = 1'b1; resp_bits = {8'h3C, 1'b0};
    issue(1'b0, 7'h7F, 8'h00);
    trace(1'b1, 1'b0);
    for (int c = 0; c < 28; c++) begin
      checks++;
      if (meas_width(c) !== exp_width(1'b0, 8'h7F, 8'h00, 1'b1, c)) begin
        errors++; $display("FAIL read cell %0d: width %0d want %0d", c, meas_width(c), exp_width(1'b0, 8'h7F, 8'h00, 1'b1, c));
      end
    end
    checks++; if (vld_first() !== 449) begin errors++; $display("FAIL read vld_cycle: got %0d want 449", vld_first()); end
    checks++; if (cap_rdat !== 8'h3C || cap_err !== 1'b0) begin
      errors++; $display("FAIL read rsp: rdat %h err %b want 3c 0", cap_rdat, cap_err);
    end
  endtask

  task automatic test_write_noresp();
    resp_active = 1'b0;
    issue(1'b1, 7'h15, 8'hA5);
    trace(1'b1, 1'b0);
    checks++; if (vld_first() !== 449) begin errors++; $display("FAIL write_noresp vld_cycle: got %0d want 449", vld_first()); end
    checks++; if (cap_err !== 1'b1 || cap_rdat !== 8'h00) begin
      errors++; $display("FAIL write_noresp rsp: err %b rdat %h want 1 00", cap_err, cap_rdat);
    end
  endtask

  task automatic test_read_bad_parity();
    resp_active = 1'b1; resp_bits = {8'h3C, 1'b1};
    issue(1'b0, 7'h7F, 8'h00);
    trace(1'b1, 1'b0);
    checks++; if (cap_rdat !== 8'h3C || cap_err !== 1'b1) begin
      errors++; $display("FAIL read_bad_parity rsp: rdat %h err %b want 3c 1", cap_rdat, cap_err);
    end
  endtask

  task automatic test_back_to_back();
    bit   got = 0;
    logic [7:0] r = 'x;
    logic e = 1'bx;
    int   rdy_hi = 0;
    resp_active = 1'b1; resp_bits = {8'h3C, 1'b0};
    issue(1'b1, 7'h15, 8'hA5);
    trace(1'b0, 1'b1);
    for (int k = 1; k <= 449; k++) if (rdy_tr[k] !== 1'b0) rdy_hi++;
    checks++; if (rdy_hi !== 0) begin errors++; $display("FAIL b2b rdy_in_frame: %0d cycles high want 0", rdy_hi); end
    for (int c = 9; c <= 16; c++) begin
      checks++;
      if (meas_width(c) !== exp_width(1'b1, 8'h95, 8'hA5, 1'b0, c)) begin
        errors++; $display("FAIL b2b hdr cell %0d: width %0d want %0d", c, meas_width(c), exp_width(1'b1, 8'h95, 8'hA5, 1'b0, c));
      end
    end
    checks++; if (vld_first() !== 449 || vld_count() !== 1) begin
      errors++; $display("FAIL b2b vld: first %0d count %0d want 449 1", vld_first(), vld_count());
    end
    checks++; if (rdy_tr[450] !== 1'b1) begin errors++; $display("FAIL b2b rdy450: got %b want 1", rdy_tr[450]); end
    checks++; if (oe_tr[451] !== 1'b1 || rdy_tr[451] !== 1'b0) begin
      errors++; $display("FAIL b2b second_accept: oe %b rdy %b want 1 0", oe_tr[451], rdy_tr[451]);
    end
    #1 cmd_vld = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (rsp_vld === 1'b1) begin got = 1; r = rsp_rdat; e = rsp_err; end
    end
    checks++; if (!got || r !== 8'h3C || e !== 1'b0) begin
      errors++; $display("FAIL b2b second_rsp: got %0d rdat %h err %b want 1 3c 0", got, r, e);
    end
  endtask

  task automatic test_reset_midframe();
    int nv = 0;
    resp_active = 1'b1; resp_bits = {8'h3C, 1'b0};
    issue(1'b1, 7'h15, 8'hA5);
    #1 cmd_vld = 1'b0;
    // Cycle 194 = HDR cell 3 (frame cell 12), offset 1; bit is 1 so OE is high.
    repeat (193) @(posedge clk);
    #3;
    checks++; if (owl_oe !== 1'b1) begin errors++; $display("FAIL midrst pre_oe: got %b want 1", owl_oe); end
    rst = 1'b1;
    #1;
    checks++; if (owl_oe !== 1'b0) begin errors++; $display("FAIL midrst oe: got %b want 0", owl_oe); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_vld !== 1'b0) nv++;
    end
    checks++; if (nv !== 0) begin errors++; $display("FAIL midrst vld: %0d pulses want 0", nv); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL midrst rdy: got %b want 1", cmd_rdy); end
    issue(1'b0, 7'h7F, 8'h00);
    trace(1'b1, 1'b0);
    for (int c = 0; c < 28; c++) begin
      checks++;
      if (meas_width(c) !== exp_width(1'b0, 8'h7F, 8'h00, 1'b1, c)) begin
        errors++; $display("FAIL midrst frame cell %0d: width %0d want %0d", c, meas_width(c), exp_width(1'b0, 8'h7F, 8'h00, 1'b1, c));
      end
    end
    checks++; if (vld_first() !== 449 || cap_rdat !== 8'h3C || cap_err !== 1'b0) begin
      errors++; $display("FAIL midrst rsp: cyc %0d rdat %h err %b want 449 3c 0", vld_first(), cap_rdat, cap_err);
    end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read();
    test_write_noresp();
    test_read_bad_parity();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
